spart_echo_top: RTL and testbench

- Top-level SPART (serial port) echo block: an 8N1 UART receiver, a UART transmitter and a small driver, all in one clock domain.
- Every byte received correctly on rxd is retransmitted unchanged on txd.
- br_cfg selects one of four baud rates.
- Sits at chip top, directly on the serial pins.

---
 rtl/spart_echo_top.sv | 229 ++++++++++++++++++++++
 tb/tb_spart_echo_top.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_echo_top.sv
// SPART echo: 8N1 UART receiver feeding a one-byte holding buffer that a UART
// transmitter drains, so every correctly framed byte on rxd is repeated on txd.
module spart_echo_top #(
    parameter int unsigned TICKS_PER_BIT = 16,
    parameter int unsigned DIV_00        = 80,
    parameter int unsigned DIV_01        = 40,
    parameter int unsigned DIV_10        = 20,
    parameter int unsigned DIV_11        = 10
) (
    input  logic       clk,
    input  logic       rst,
    output logic       txd,
    input  logic       rxd,
    input  logic [1:0] br_cfg
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned TCK_W = $clog2(TICKS_PER_BIT);

    localparam logic [TCK_W-1:0] TCK_MID  = TCK_W'(TICKS_PER_BIT / 2 - 1);
    localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(TICKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [DIV_W-1:0] div_q, div_sel_c, tick_cnt_q, tick_cnt_d;
    logic             tick_c;
    logic             rxd_meta_q, rxd_s_q;

    logic [1:0]       rx_state_q, rx_state_d;
    logic [TCK_W-1:0] rx_tcnt_q, rx_tcnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_valid_c;

    logic [7:0]       hold_q, hold_d;
    logic             full_q, full_d;

    logic [1:0]       tx_state_q, tx_state_d;
    logic [TCK_W-1:0] tx_tcnt_q, tx_tcnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_d;
    logic             tx_load_c, tx_avail_c;
    logic [7:0]       tx_byte_c;

    // Divisor chosen by br_cfg; only captured while rst is high.
    always_comb begin
        case (br_cfg)
            2'b00:   div_sel_c = DIV_W'(DIV_00);
            2'b01:   div_sel_c = DIV_W'(DIV_01);
            2'b10:   div_sel_c = DIV_W'(DIV_10);
            default: div_sel_c = DIV_W'(DIV_11);
        endcase
    end

    assign tick_c = (tick_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= div_sel_c;
            tick_cnt_q <= '0;
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd        <= 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd        <= txd_d;
        end
    end

    assign tick_cnt_d = tick_c ? (div_q - DIV_W'(1)) : (tick_cnt_q - DIV_W'(1));

    // Receiver: start detect, mid-bit start qualification, 16-tick data/stop sampling.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_c = 1'b0;
        if (tick_c) begin
            case (rx_state_q)
                S_IDLE: begin
                    if (!rxd_s_q) begin
                        rx_state_d = S_START;
                        rx_tcnt_d  = '0;
                    end
                end
                S_START: begin
                    if (rx_tcnt_q == TCK_MID) begin
                        rx_tcnt_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rxd_s_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + TCK_W'(1);
                    end
                end
                S_DATA: begin
                    if (rx_tcnt_q == TCK_LAST) begin
                        rx_tcnt_d  = '0;
                        rx_shift_d = {rxd_s_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = S_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + TCK_W'(1);
                    end
                end
                S_STOP: begin
                    if (rx_tcnt_q == TCK_LAST) begin
                        rx_tcnt_d  = '0;
                        rx_state_d = S_IDLE;
                        rx_valid_c = rxd_s_q;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + TCK_W'(1);
                    end
                end
                default: rx_state_d = S_IDLE;
            endcase
        end
    end

    // A byte completing on this tick is handed straight to an idle transmitter.
    assign tx_avail_c = full_q | rx_valid_c;
    assign tx_byte_c  = rx_valid_c ? rx_shift_q : hold_q;

    // Transmitter: every bit held for exactly TICKS_PER_BIT ticks.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd;
        tx_load_c  = 1'b0;
        if (tick_c) begin
            case (tx_state_q)
                S_IDLE: begin
                    if (tx_avail_c) begin
                        tx_load_c  = 1'b1;
                        tx_state_d = S_START;
                        tx_tcnt_d  = '0;
                        tx_shift_d = tx_byte_c;
                        txd_d      = 1'b0;
                    end
                end
                S_START: begin
                    if (tx_tcnt_q == TCK_LAST) begin
                        tx_state_d = S_DATA;
                        tx_tcnt_d  = '0;
                        tx_bit_d   = '0;
                        txd_d      = tx_shift_q[0];
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + TCK_W'(1);
                    end
                end
                S_DATA: begin
                    if (tx_tcnt_q == TCK_LAST) begin
                        tx_tcnt_d = '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = S_STOP;
                            txd_d      = 1'b1;
                        end else begin
                            tx_bit_d   = tx_bit_q + 3'd1;
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                            txd_d      = tx_shift_q[1];
                        end
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + TCK_W'(1);
                    end
                end
                S_STOP: begin
                    if (tx_tcnt_q == TCK_LAST) begin
                        tx_tcnt_d = '0;
                        if (tx_avail_c) begin
                            tx_load_c  = 1'b1;
                            tx_state_d = S_START;
                            tx_shift_d = tx_byte_c;
                            txd_d      = 1'b0;
                        end else begin
                            tx_state_d = S_IDLE;
                        end
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + TCK_W'(1);
                    end
                end
                default: tx_state_d = S_IDLE;
            endcase
        end
    end

    // Holding buffer: newest byte wins; a load by the transmitter empties it.
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (tx_load_c) begin
            full_d = 1'b0;
        end else if (rx_valid_c) begin
            hold_d = rx_shift_q;
            full_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_spart_echo_top.sv
// Directed bench for spart_echo_top: drives serial frames on rxd and decodes txd.
module tb_spart_echo_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       txd;
    logic       rxd;
    logic [1:0] br_cfg;

    always #5 clk = ~clk;

    spart_echo_top dut (
        .clk    (clk),
        .rst    (rst),
        .txd    (txd),
        .rxd    (rxd),
        .br_cfg (br_cfg)
    );

    typedef struct {
        logic [1:0] br;
        logic [1:0] br_run;
        logic [7:0] data;
        logic       stop;
        logic       echo;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int low_cnt  = 0;
    int mon_bit  = 160;
    logic [8:0] mon_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (txd === 1'b0) low_cnt <= low_cnt + 1;

    // Frame decoder on txd: samples each bit at its centre, queues {stop, data}.
    initial begin : monitor
        int bt;
        logic [8:0] fr;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && txd === 1'b0) begin
                bt = mon_bit;
                repeat (bt / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (bt) @(negedge clk);
                    fr[i] = txd;
                end
                repeat (bt) @(negedge clk);
                fr[8] = txd;
                mon_q.push_back(fr);
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int bit_clks(input logic [1:0] br);
        case (br)
            2'b00:   return 1280;
            2'b01:   return 640;
            2'b10:   return 320;
            default: return 160;
        endcase
    endfunction

    task automatic do_reset(input logic [1:0] br);
        @(negedge clk);
        rst    = 1'b1;
        rxd    = 1'b1;
        br_cfg = br;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bt);
        rxd = 1'b0;
        repeat (bt) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (bt) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (bt) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int limit);
        int k;
        k = 0;
        while (mon_q.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
    endtask

    // 0xA5 on the line: start, 1,0,1,0,0,1,0,1, stop -> run lengths in bits.
    task automatic measure_a5();
        int   runs [7];
        int   k;
        int   len;
        logic lvl;
        runs = '{1, 1, 1, 1, 2, 1, 1};
        k = 0;
        while (txd !== 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("a5_start_seen", 32'(txd), 32'h0);
        for (int r = 0; r < 7; r++) begin
            lvl = txd;
            len = 0;
            while (txd === lvl && len < 400) begin
                @(negedge clk);
                len++;
            end
            check_range($sformatf("a5_run%0d_len", r), len, runs[r] * 160 - 1, runs[r] * 160 + 1);
        end
        k = 0;
        while (txd === 1'b1 && k < 320) begin
            @(negedge clk);
            k++;
        end
        check("a5_tail_high_len", 32'(k), 32'd320);
    endtask

    initial begin : main
        vec_t vecs [5];
        int   l0;
        int   t0;
        int   t_fall;
        int   k;
        int   bt;

        vecs[0] = '{br: 2'b11, br_run: 2'b11, data: 8'h00, stop: 1'b1, echo: 1'b1};
        vecs[1] = '{br: 2'b11, br_run: 2'b11, data: 8'hFF, stop: 1'b1, echo: 1'b1};
        vecs[2] = '{br: 2'b10, br_run: 2'b10, data: 8'h96, stop: 1'b1, echo: 1'b1};
        vecs[3] = '{br: 2'b11, br_run: 2'b00, data: 8'h5C, stop: 1'b1, echo: 1'b1};
        vecs[4] = '{br: 2'b11, br_run: 2'b11, data: 8'h81, stop: 1'b0, echo: 1'b0};

        // Reset held three clocks with the line idle, then a long quiet interval.
        rst    = 1'b1;
        rxd    = 1'b1;
        br_cfg = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_txd_%0d", i), 32'(txd), 32'h1);
        end
        rst = 1'b0;
        l0  = low_cnt;
        repeat (5000) @(negedge clk);
        check("idle_txd_low_cycles", 32'(low_cnt - l0), 32'h0);
        check("idle_no_frames", 32'(mon_q.size()), 32'h0);

        // Single-frame vectors, including a br_cfg change after reset and a framing error.
        for (int v = 0; v < 5; v++) begin
            do_reset(vecs[v].br);
            br_cfg  = vecs[v].br_run;
            bt      = bit_clks(vecs[v].br);
            mon_bit = bt;
            l0      = low_cnt;
            send_byte(vecs[v].data, vecs[v].stop, bt);
            if (vecs[v].echo) begin
                wait_frames(1, 12 * bt);
                check($sformatf("vec%0d_frames", v), 32'(mon_q.size()), 32'h1);
                if (mon_q.size() > 0) begin
                    check($sformatf("vec%0d_data", v), 32'(mon_q[0][7:0]), 32'(vecs[v].data));
                    check($sformatf("vec%0d_stop", v), 32'(mon_q[0][8]), 32'h1);
                end
                repeat (bt) @(negedge clk);
            end else begin
                repeat (4 * bt) @(negedge clk);
                check($sformatf("vec%0d_frames", v), 32'(mon_q.size()), 32'h0);
                check($sformatf("vec%0d_txd_low", v), 32'(low_cnt - l0), 32'h0);
            end
        end

        // 0x45 at 640 clk/bit; start of echo measured from the RX stop-bit centre.
        do_reset(2'b01);
        mon_bit = 640;
        t0      = cyc;
        t_fall  = -1;
        fork
            send_byte(8'h45, 1'b1, 640);
            begin
                k = 0;
                while (txd !== 1'b0 && k < 8000) begin
                    @(negedge clk);
                    k++;
                end
                t_fall = cyc;
            end
        join
        // One tick (40 clocks) of start-detect quantisation plus synchronizer/register delay.
        check_range("b45_start_latency", t_fall - (t0 + 6080), 0, 46);
        wait_frames(1, 8000);
        check("b45_frames", 32'(mon_q.size()), 32'h1);
        if (mon_q.size() > 0) check("b45_data", 32'(mon_q[0]), 32'h145);
        repeat (640) @(negedge clk);

        // 0xA5 at 160 clk/bit: exact bit durations on txd.
        do_reset(2'b11);
        mon_bit = 160;
        fork
            send_byte(8'hA5, 1'b1, 160);
            measure_a5();
        join
        wait_frames(1, 2000);
        if (mon_q.size() > 0) check("a5_data", 32'(mon_q[0]), 32'h1A5);
        else check("a5_frames", 32'(mon_q.size()), 32'h1);
        repeat (200) @(negedge clk);

        // Framing error is dropped; the receiver then recovers for a valid byte.
        do_reset(2'b11);
        mon_bit = 160;
        l0      = low_cnt;
        send_byte(8'h3C, 1'b0, 160);
        repeat (640) @(negedge clk);
        check("ferr_txd_low", 32'(low_cnt - l0), 32'h0);
        check("ferr_frames", 32'(mon_q.size()), 32'h0);
        send_byte(8'h5A, 1'b1, 160);
        wait_frames(1, 2000);
        check("ferr_recover_frames", 32'(mon_q.size()), 32'h1);
        if (mon_q.size() > 0) check("ferr_recover_data", 32'(mon_q[0]), 32'h15A);
        repeat (200) @(negedge clk);

        // 100-clock low glitch at 640 clk/bit is rejected at start-bit centre.
        do_reset(2'b01);
        mon_bit = 640;
        l0      = low_cnt;
        rxd     = 1'b0;
        repeat (100) @(negedge clk);
        rxd = 1'b1;
        repeat (2000) @(negedge clk);
        check("glitch_txd_low", 32'(low_cnt - l0), 32'h0);
        check("glitch_frames", 32'(mon_q.size()), 32'h0);

        // Back-to-back frames with no idle time between them.
        do_reset(2'b11);
        mon_bit = 160;
        send_byte(8'h11, 1'b1, 160);
        send_byte(8'h22, 1'b1, 160);
        send_byte(8'h33, 1'b1, 160);
        wait_frames(3, 3000);
        check("b2b_frames", 32'(mon_q.size()), 32'h3);
        if (mon_q.size() == 3) begin
            check("b2b_0", 32'(mon_q[0]), 32'h111);
            check("b2b_1", 32'(mon_q[1]), 32'h122);
            check("b2b_2", 32'(mon_q[2]), 32'h133);
        end
        repeat (200) @(negedge clk);

        // Reset during an outgoing frame forces txd high and leaves nothing pending.
        do_reset(2'b11);
        mon_bit = 160;
        send_byte(8'h0F, 1'b1, 160);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midframe_rst_txd", 32'(txd), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        l0  = low_cnt;
        repeat (2000) @(negedge clk);
        check("midframe_after_txd_low", 32'(low_cnt - l0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
